// File: rtl/usr_seq_shifter.sv
// usr_seq_shifter: command-driven universal shift register.
// A command (op + amount) is accepted over a valid/ready handshake. HOLD, LOAD and CLEAR,
// and shift/rotate ops with amount 0, complete on the accept edge. Shift/rotate ops with a
// nonzero amount run one bit per clock and report each bit shifted out.
//
// Ports:
//   clock, reset      rising-edge clock; synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_op, cmd_amt   opcode and single-bit step count
//   din               parallel load data
//   sin_left          serial bit entering the MSB on SHR
//   sin_right         serial bit entering the LSB on SHL
//   dout              register contents
//   sout, sout_valid  bit shifted out on the latest step; one-cycle valid pulse per step
//   busy, done        multi-cycle command in progress; one-cycle completion pulse
module usr_seq_shifter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_left,
    input  logic             sin_right,
    output logic [WIDTH-1:0] dout,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OpHold  = 3'b000;
    localparam logic [2:0] OpShr   = 3'b001;
    localparam logic [2:0] OpShl   = 3'b010;
    localparam logic [2:0] OpLoad  = 3'b011;
    localparam logic [2:0] OpRor   = 3'b100;
    localparam logic [2:0] OpRol   = 3'b101;
    localparam logic [2:0] OpAsr   = 3'b110;
    localparam logic [2:0] OpClear = 3'b111;

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e             state_q, state_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               sout_q, sout_d;
    logic               sout_valid_q, sout_valid_d;
    logic               done_q, done_d;

    logic               accept;
    logic               is_shift_op;
    logic [WIDTH:0]     step_res;

    // One single-bit step of a shift/rotate op; returns {bit_out, new_value}.
    function automatic logic [WIDTH:0] step(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] v,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH:0] r;
        unique case (op)
            OpShr:   r = {v[0],       sl,          v[WIDTH-1:1]};
            OpShl:   r = {v[WIDTH-1], v[WIDTH-2:0], sr};
            OpRor:   r = {v[0],       v[0],        v[WIDTH-1:1]};
            OpRol:   r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            OpAsr:   r = {v[0],       v[WIDTH-1],  v[WIDTH-1:1]};
            default: r = {1'b0, v};
        endcase
        return r;
    endfunction

    always_comb begin
        unique case (cmd_op)
            OpShr, OpShl, OpRor, OpRol, OpAsr: is_shift_op = 1'b1;
            default:                           is_shift_op = 1'b0;
        endcase
    end

    assign accept   = cmd_valid && (state_q == StIdle);
    assign step_res = step(op_q, dout_q, sin_left, sin_right);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        dout_d       = dout_q;
        sout_d       = sout_q;
        sout_valid_d = 1'b0;
        done_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_shift_op && (cmd_amt != '0)) begin
                        // Latch the op; the first step happens on the next edge.
                        state_d = StShift;
                        cnt_d   = cmd_amt;
                        op_d    = cmd_op;
                    end else begin
                        done_d = 1'b1;
                        if (cmd_op == OpLoad) begin
                            dout_d = din;
                        end else if (cmd_op == OpClear) begin
                            dout_d = '0;
                        end
                    end
                end
            end
            StShift: begin
                dout_d       = step_res[WIDTH-1:0];
                sout_d       = step_res[WIDTH];
                sout_valid_d = 1'b1;
                cnt_d        = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            op_q         <= OpHold;
            dout_q       <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            dout_q       <= dout_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign busy       = (state_q == StShift);
    assign dout       = dout_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_usr_seq_shifter.sv
// Testbench for usr_seq_shifter: directed test-plan steps followed by random commands,
// checked against a cycle-level behavioural model built from plain integer arithmetic.
module tb_usr_seq_shifter;

    localparam int W = 8;
    localparam int A = 4;

    logic         clock;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [A-1:0] cmd_amt;
    logic [W-1:0] din;
    logic         sin_left;
    logic         sin_right;
    logic [W-1:0] dout;
    logic         sout;
    logic         sout_valid;
    logic         busy;
    logic         done;

    usr_seq_shifter #(
        .WIDTH(W),
        .AMT_W(A)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .din       (din),
        .sin_left  (sin_left),
        .sin_right (sin_right),
        .dout      (dout),
        .sout      (sout),
        .sout_valid(sout_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Model state
    int unsigned m_dout = 0;
    int unsigned m_sout = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit is_sh(input int unsigned op);
        return (op == 1) || (op == 2) || (op == 4) || (op == 5) || (op == 6);
    endfunction

    // One step of the reference model: updates m_dout/m_sout.
    task automatic model_step(input int unsigned op, input int unsigned sl, input int unsigned sr);
        int unsigned top  = 1 << (W - 1);
        int unsigned mask = (1 << W) - 1;
        int unsigned lsb  = m_dout % 2;
        int unsigned msb  = m_dout / top;
        case (op)
            1: begin m_sout = lsb; m_dout = m_dout / 2 + sl * top; end
            2: begin m_sout = msb; m_dout = (m_dout * 2 + sr) & mask; end
            4: begin m_sout = lsb; m_dout = m_dout / 2 + lsb * top; end
            5: begin m_sout = msb; m_dout = (m_dout * 2 + msb) & mask; end
            6: begin m_sout = lsb; m_dout = m_dout / 2 + msb * top; end
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag, input int unsigned e_done, input int unsigned e_busy,
                             input int unsigned e_sv);
        chk({tag, ".dout"},  32'(dout), m_dout);
        chk({tag, ".sout"},  32'(sout), m_sout);
        chk({tag, ".svld"},  32'(sout_valid), e_sv);
        chk({tag, ".done"},  32'(done), e_done);
        chk({tag, ".busy"},  32'(busy), e_busy);
        chk({tag, ".ready"}, 32'(cmd_ready), 32'(e_busy == 0));
    endtask

    // Called just after a negedge; offers a command and returns just after the next negedge.
    task automatic issue(input int unsigned op, input int unsigned amt, input int unsigned d);
        chk("issue.ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op[2:0];
        cmd_amt   = amt[A-1:0];
        din       = d[W-1:0];
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_amt   = A'($urandom);
        din       = W'($urandom);
        if (is_sh(op) && amt != 0) begin
            check_all("accept", 0, 1, 0);
        end else begin
            if (op == 3) m_dout = d & ((1 << W) - 1);
            if (op == 7) m_dout = 0;
            check_all("imm", 1, 0, 0);
        end
    endtask

    // Runs cnt steps of an n-step command; sin is random per step when rnd is set.
    task automatic steps(input int unsigned op, input int unsigned n, input int unsigned cnt,
                         input bit rnd, input int unsigned sl, input int unsigned sr);
        int unsigned l, r;
        for (int i = 1; i <= int'(cnt); i++) begin
            l = rnd ? $urandom_range(0, 1) : sl;
            r = rnd ? $urandom_range(0, 1) : sr;
            sin_left  = l[0];
            sin_right = r[0];
            @(posedge clock);
            @(negedge clock);
            model_step(op, l, r);
            check_all("step", (i == int'(n)) ? 1 : 0, (i == int'(n)) ? 0 : 1, 1);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            @(posedge clock);
            @(negedge clock);
            check_all("idle", 0, 0, 0);
        end
    endtask

    initial begin
        int unsigned op, amt;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_amt   = '0;
        din       = '0;
        sin_left  = 1'b0;
        sin_right = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_all("reset", 0, 0, 0);
        reset = 1'b0;
        idle(1);

        // LOAD 0xA5
        issue(3, 0, 8'hA5);
        chk("load_a5", 32'(dout), 32'hA5);
        idle(1);

        // SHR 3 with sin_left = 1: D2, E9, F4; sout 1, 0, 1
        issue(1, 3, 0);
        steps(1, 3, 1, 0, 1, 0);
        chk("shr_s1", 32'(dout), 32'hD2);
        chk("shr_o1", 32'(sout), 1);
        steps(1, 3, 1, 0, 1, 0);
        chk("shr_s2", 32'(dout), 32'hE9);
        chk("shr_o2", 32'(sout), 0);
        // third (final) step: done expected, handled in-line
        sin_left = 1'b1;
        @(posedge clock);
        @(negedge clock);
        model_step(1, 1, 0);
        check_all("shr_last", 1, 0, 1);
        chk("shr_s3", 32'(dout), 32'hF4);
        chk("shr_o3", 32'(sout), 1);
        idle(1);

        issue(3, 0, 8'h3C);
        issue(5, 4, 0);
        steps(5, 4, 4, 1, 0, 0);
        chk("rol4", 32'(dout), 32'hC3);
        issue(3, 0, 8'h90);
        issue(6, 2, 0);
        steps(6, 2, 2, 1, 0, 0);
        chk("asr2", 32'(dout), 32'hE4);
        issue(3, 0, 8'hFF);
        issue(2, 9, 0);
        steps(2, 9, 9, 0, 0, 0);
        chk("shl9", 32'(dout), 32'h00);
        idle(1);

        // CLEAR held valid while SHR 5 runs: accepted only on the edge after done
        issue(3, 0, 8'h5A);
        issue(1, 5, 0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd7;
        cmd_amt   = 4'd3;
        din       = 8'hFF;
        steps(1, 5, 5, 1, 0, 0);
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        m_dout = 0;
        check_all("clr_after", 1, 0, 0);
        idle(1);

        // SHL 0 and HOLD are immediate
        issue(3, 0, 8'h77);
        issue(2, 0, 0);
        chk("shl0", 32'(dout), 32'h77);
        idle(1);
        issue(0, 5, 8'h12);
        chk("hold", 32'(dout), 32'h77);
        idle(1);

        // Reset in the middle of ROR 6
        issue(3, 0, 8'h81);
        issue(4, 6, 0);
        steps(4, 6, 2, 1, 0, 0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset  = 1'b0;
        m_dout = 0;
        m_sout = 0;
        check_all("mid_reset", 0, 0, 0);
        idle(8);

        // Random commands
        for (int k = 0; k < 40; k++) begin
            op  = $urandom_range(0, 7);
            amt = $urandom_range(0, 11);
            issue(op, amt, $urandom);
            if (is_sh(op) && amt != 0) steps(op, amt, amt, 1, 0, 0);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
